// File: rtl/lifo_stack.sv
// lifo_stack: DEPTH x DATA_W synchronous stack with optional first-word-fall-through read port.
// Define LIFO_STACK_ERR_EN to add registered overflow/underflow pulse outputs err_ovf and err_unf.
module lifo_stack #(
  parameter string        FWFT_MODE = "FALSE",
  parameter int unsigned  DEPTH     = 8,
  parameter int unsigned  DATA_W    = 32,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              w_req,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_req,
  output logic [DATA_W-1:0] r_data,
  output logic [CNT_W-1:0]  cnt,
  output logic              empty,
  output logic              full
`ifdef LIFO_STACK_ERR_EN
  ,
  output logic              err_ovf,
  output logic              err_unf
`endif
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          FWFT = (FWFT_MODE == "TRUE");

  if ((FWFT_MODE != "TRUE") && (FWFT_MODE != "FALSE")) begin : g_bad_mode
    $error("lifo_stack: FWFT_MODE must be \"TRUE\" or \"FALSE\"");
  end

  if (DEPTH < 2) begin : g_bad_depth
    $error("lifo_stack: DEPTH must be at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              push_only;
  logic              pop_only;
  logic              replace;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     below_idx;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] rdata_n;
  logic              mem_we;
  logic [AW-1:0]     mem_widx;

  // Request decode and next-state; flags and r_data are registered from these.
  always_comb begin
    push_only = w_req & ~full & (~r_req | empty);
    pop_only  = r_req & ~w_req & ~empty;
    replace   = w_req & r_req & ~empty;
    wr_idx    = AW'(cnt);
    top_idx   = AW'(cnt - CNT_W'(1));
    below_idx = AW'(cnt - CNT_W'(2));

    cnt_n    = cnt;
    rdata_n  = r_data;
    mem_we   = 1'b0;
    mem_widx = wr_idx;

    if (push_only) begin
      cnt_n    = cnt + CNT_W'(1);
      mem_we   = 1'b1;
      mem_widx = wr_idx;
    end else if (pop_only) begin
      cnt_n = cnt - CNT_W'(1);
    end else if (replace) begin
      mem_we   = 1'b1;
      mem_widx = top_idx;
    end

    // FWFT keeps r_data equal to the post-edge top of stack, so it stays a flop output.
    if (FWFT) begin
      if (push_only || replace) begin
        rdata_n = w_data;
      end else if (pop_only) begin
        rdata_n = (cnt > CNT_W'(1)) ? mem[below_idx] : '0;
      end
    end else begin
      if (pop_only || replace) begin
        rdata_n = mem[top_idx];
      end
    end
  end

  // Control state; storage below is deliberately left out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      r_data <= '0;
    end else begin
      cnt    <= cnt_n;
      empty  <= (cnt_n == '0);
      full   <= (cnt_n == CNT_W'(DEPTH));
      r_data <= rdata_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= w_data;
    end
  end

`ifdef LIFO_STACK_ERR_EN
  // A push with pop at full is a replace-top, so only a lone push counts as overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= w_req & ~r_req & full;
      err_unf <= r_req & ~w_req & empty;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: drives a non-FWFT and an FWFT stack with shared stimulus and checks both
// against a queue model every cycle, plus hand-computed checks on the directed sequences.
module tb_lifo_stack;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              nrst;
  logic              w_req;
  logic [DATA_W-1:0] w_data;
  logic              r_req;
  logic [DATA_W-1:0] nf_rdata, ff_rdata;
  logic [CNT_W-1:0]  nf_cnt, ff_cnt;
  logic              nf_empty, ff_empty, nf_full, ff_full;
`ifdef LIFO_STACK_ERR_EN
  logic              nf_ovf, nf_unf, ff_ovf, ff_unf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  lifo_stack #(.FWFT_MODE("FALSE"), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_nf (
    .clk(clk), .nrst(nrst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
    .r_data(nf_rdata), .cnt(nf_cnt), .empty(nf_empty), .full(nf_full)
`ifdef LIFO_STACK_ERR_EN
    , .err_ovf(nf_ovf), .err_unf(nf_unf)
`endif
  );

  lifo_stack #(.FWFT_MODE("TRUE"), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_ff (
    .clk(clk), .nrst(nrst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
    .r_data(ff_rdata), .cnt(ff_cnt), .empty(ff_empty), .full(ff_full)
`ifdef LIFO_STACK_ERR_EN
    , .err_ovf(ff_ovf), .err_unf(ff_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a queue whose back is the top of stack.
  logic [DATA_W-1:0] stk [$];
  logic [DATA_W-1:0] m_nf;
  logic              m_ovf, m_unf;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stk.delete();
      m_nf  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (w_req && r_req && stk.size() > 0) begin
        m_nf = stk[stk.size()-1];
        stk[stk.size()-1] = w_data;
      end else if (w_req && !r_req && stk.size() == int'(DEPTH)) begin
        m_ovf = 1'b1;
      end else if (w_req) begin
        stk.push_back(w_data);
      end else if (r_req && stk.size() > 0) begin
        m_nf = stk.pop_back();
      end else if (r_req) begin
        m_unf = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [31:0] sz;
    logic [31:0] top;
    sz  = 32'(stk.size());
    top = (stk.size() > 0) ? 32'(stk[stk.size()-1]) : 32'd0;
    check("nf_cnt", 32'(nf_cnt), sz);
    check("ff_cnt", 32'(ff_cnt), sz);
    check("nf_empty", 32'(nf_empty), 32'(sz == 0));
    check("ff_empty", 32'(ff_empty), 32'(sz == 0));
    check("nf_full", 32'(nf_full), 32'(sz == DEPTH));
    check("ff_full", 32'(ff_full), 32'(sz == DEPTH));
    check("nf_rdata", 32'(nf_rdata), 32'(m_nf));
    check("ff_rdata", 32'(ff_rdata), top);
`ifdef LIFO_STACK_ERR_EN
    check("nf_ovf", 32'(nf_ovf), 32'(m_ovf));
    check("ff_ovf", 32'(ff_ovf), 32'(m_ovf));
    check("nf_unf", 32'(nf_unf), 32'(m_unf));
    check("ff_unf", 32'(ff_unf), 32'(m_unf));
`endif
  end

  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
    w_req  = w;
    w_data = d;
    r_req  = r;
    @(posedge clk);
    #1;
    w_req = 1'b0;
    r_req = 1'b0;
  endtask

  initial begin
    nrst   = 1'b1;
    w_req  = 1'b0;
    r_req  = 1'b0;
    w_data = '0;
    #1 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // Reset state
    check("rst_cnt", 32'(nf_cnt), 32'd0);
    check("rst_empty", 32'(ff_empty), 32'd1);
    check("rst_full", 32'(nf_full), 32'd0);
    check("rst_nf_rdata", 32'(nf_rdata), 32'd0);
    check("rst_ff_rdata", 32'(ff_rdata), 32'd0);

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(i), 1'b0);
    check("fill_cnt", 32'(nf_cnt), 32'd8);
    check("fill_full", 32'(ff_full), 32'd1);
    check("fill_ff_top", 32'(ff_rdata), 32'h0008);
    step(1'b1, 16'h0009, 1'b0);
    check("ovf_cnt", 32'(ff_cnt), 32'd8);
    check("ovf_ff_top", 32'(ff_rdata), 32'h0008);
`ifdef LIFO_STACK_ERR_EN
    check("ovf_pulse", 32'(nf_ovf), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    check("ovf_pulse_end", 32'(nf_ovf), 32'd0);
`endif

    // Drain in LIFO order
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      check("pop_nf", 32'(nf_rdata), 32'(8 - i));
      check("pop_ff", 32'(ff_rdata), 32'(7 - i));
    end
    check("drain_cnt", 32'(nf_cnt), 32'd0);
    check("drain_empty", 32'(nf_empty), 32'd1);

    // Pop on empty
    step(1'b0, 16'h0000, 1'b1);
    check("unf_cnt", 32'(nf_cnt), 32'd0);
    check("unf_nf_hold", 32'(nf_rdata), 32'h0001);
    check("unf_ff_zero", 32'(ff_rdata), 32'd0);
`ifdef LIFO_STACK_ERR_EN
    check("unf_pulse", 32'(ff_unf), 32'd1);
`endif

    // Replace-top
    step(1'b1, 16'h00AA, 1'b0);
    step(1'b1, 16'h00BB, 1'b0);
    step(1'b1, 16'h00CC, 1'b1);
    check("rep_nf", 32'(nf_rdata), 32'h00BB);
    check("rep_cnt", 32'(nf_cnt), 32'd2);
    check("rep_ff", 32'(ff_rdata), 32'h00CC);
    step(1'b0, 16'h0000, 1'b1);
    check("rep_pop_nf", 32'(nf_rdata), 32'h00CC);
    check("rep_pop_ff", 32'(ff_rdata), 32'h00AA);
    step(1'b0, 16'h0000, 1'b1);
    check("rep_last_nf", 32'(nf_rdata), 32'h00AA);

    // Reset in the middle of a burst
    step(1'b1, 16'h0001, 1'b0);
    step(1'b1, 16'h0002, 1'b0);
    w_req  = 1'b1;
    w_data = 16'h0003;
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_cnt", 32'(nf_cnt), 32'd0);
    check("mid_rst_empty", 32'(ff_empty), 32'd1);
    check("mid_rst_ff", 32'(ff_rdata), 32'd0);
    w_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    step(1'b1, 16'h1234, 1'b0);
    check("post_rst_ff", 32'(ff_rdata), 32'h1234);
    step(1'b0, 16'h0000, 1'b1);
    check("post_rst_nf", 32'(nf_rdata), 32'h1234);
    check("post_rst_cnt", 32'(nf_cnt), 32'd0);

    // Random traffic: balanced, then push-heavy and pop-heavy to visit both bounds
    for (int i = 0; i < 10000; i++) begin
      int unsigned pw, pr;
      pw = (i >= 5000 && i < 7500) ? 50 : 25;
      pr = (i >= 7500) ? 50 : 25;
      step(1'($urandom_range(99) < pw), DATA_W'($urandom), 1'($urandom_range(99) < pr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
